// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding and the default operand widths.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW = $clog2(DW_DEF + 1);
  localparam logic [DW_DEF-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Ports: r_i partial remainder, bit_i next dividend bit, d_i divisor,
//        r_o next partial remainder, q_o quotient bit.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);

  logic [VW+1:0] t;
  logic [VW+1:0] d_ext;

  assign t     = {r_i, bit_i};
  assign d_ext = (VW+2)'(d_i);
  assign q_o   = (t >= d_ext);
  assign r_o   = q_o ? (VW+1)'(t - d_ext) : t[VW:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (sync, active-low), start, dividend, divisor in;
//        busy, done, div_by_zero, quotient, remainder out.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CNT_W = $clog2(DW + 1);

  state_e         state_q, state_d;
  logic [VW:0]    r_q, r_d;
  logic [DW-1:0]  q_q, q_d;
  logic [VW-1:0]  d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]  quot_q, quot_d;
  logic [VW-1:0]  rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [VW:0]    r_nxt;
  logic           qbit;
  logic [DW-1:0]  q_shift;
  logic           accept;

  div_step #(
    .VW(VW)
  ) u_step (
    .r_i  (r_q),
    .bit_i(q_q[DW-1]),
    .d_i  (d_q),
    .r_o  (r_nxt),
    .q_o  (qbit)
  );

  assign q_shift = {q_q[DW-2:0], qbit};
  assign accept  = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      RUN: begin
        r_d   = r_nxt;
        q_d   = q_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DW - 1)) begin
          state_d = DONE;
          quot_d  = q_shift;
          rem_d   = r_nxt[VW-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A new request overrides the DONE->IDLE fall-through.
    if (accept) begin
      d_d   = divisor;
      r_d   = '0;
      q_d   = dividend;
      cnt_d = '0;
      if (divisor == '0) begin
        state_d = DONE;
        quot_d  = '1;
        rem_d   = '0;
        dbz_d   = 1'b1;
      end else begin
        state_d = RUN;
        quot_d  = '0;
        rem_d   = '0;
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider.
// Scoreboard queue of expected results, popped on each done pulse.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  seq_restoring_divider #(
    .DW(8),
    .VW(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF;
      e.r = 4'd0;
      e.z = 1'b1;
    end else begin
      e.q = a / 8'(b);
      e.r = 4'(a % 8'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE/DONE, wait for its done and score it.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input string tag);
    exp_t e;
    int   lat;
    int   nbusy;
    bit   seen;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    tick;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    if (b != 4'd0) begin
      n_checks++;
      if (busy !== 1'b1 || quotient !== 8'd0 || remainder !== 4'd0 ||
          div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL %s clear_on_start: busy=%b q=%0d r=%0d z=%b, need 1/0/0/0",
                 tag, busy, quotient, remainder, div_by_zero);
      end
    end
    lat   = 1;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && lat <= 20) begin
      n_checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        n_fail++;
        $display("FAIL %s busy_and_done: both high at cycle %0d, need exclusive",
                 tag, lat);
      end
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        tick;
        lat++;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no done in %0d cycles, need done", tag, lat);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
      n_fail++;
      $display("FAIL %s result: got q=%0d r=%0d z=%b, need q=%0d r=%0d z=%b",
               tag, quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    n_checks++;
    if (lat != ((b == 4'd0) ? 1 : 9) || nbusy != ((b == 4'd0) ? 0 : 8)) begin
      n_fail++;
      $display("FAIL %s latency: got done@%0d busy=%0d, need done@%0d busy=%0d",
               tag, lat, nbusy, (b == 4'd0) ? 1 : 9, (b == 4'd0) ? 0 : 8);
    end
    if (b != 4'd0) begin
      n_checks++;
      if (int'(quotient) * int'(b) + int'(remainder) != int'(a) ||
          remainder >= b) begin
        n_fail++;
        $display("FAIL %s invariant: q=%0d r=%0d for %0d/%0d", tag, quotient,
                 remainder, a, b);
      end
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_drop: done=%b busy=%b, need 0/0", tag, done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (2) tick;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
        quotient !== 8'd0 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: b=%b d=%b z=%b q=%0d r=%0d, need all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    tick;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, need 0/0", busy, done);
    end
  endtask

  task automatic test_basic;
    run_div(8'd200, 4'd7, "div_200_7");
  endtask

  task automatic test_edges;
    run_div(8'd255, 4'd1, "div_255_1");
    run_div(8'd5, 4'd9, "div_5_9");
    run_div(8'd0, 4'd15, "div_0_15");
  endtask

  task automatic test_div_by_zero;
    run_div(8'd123, 4'd0, "div_123_0");
    repeat (2) tick;
    n_checks++;
    if (div_by_zero !== 1'b1 || quotient !== 8'hFF || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL dbz_hold: z=%b q=%0d r=%0d, need 1/255/0",
               div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_ignore_in_run;
    exp_t e;
    int   lat;
    int   ndone;
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    sb.push_back(model(8'd100, 4'd3));
    tick;
    start = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_busy4: busy=%b, need 1", busy);
    end
    dividend = 8'd50;
    divisor  = 4'd5;
    start    = 1'b1;
    tick;
    start    = 1'b0;
    dividend = 8'd7;
    divisor  = 4'd2;
    lat      = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_timeout: no done after %0d cycles, need done", lat);
      sb.delete();
    end else begin
      e = sb.pop_front();
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
        n_fail++;
        $display("FAIL ignore_result: got q=%0d r=%0d, need q=%0d r=%0d",
                 quotient, remainder, e.q, e.r);
      end
    end
    ndone = 0;
    repeat (15) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL ignore_queued: %0d busy/done cycles after result, need 0",
               ndone);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    dividend = 8'd240;
    divisor  = 4'd15;
    start    = 1'b1;
    sb.push_back(model(8'd240, 4'd15));
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    sb.delete();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
        quotient !== 8'd0 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_state: b=%b d=%b z=%b q=%0d r=%0d, need all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    ndone = 0;
    repeat (20) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL midreset_done: %0d busy/done cycles after abort, need 0",
               ndone);
    end
    run_div(8'd9, 4'd2, "div_9_2");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    dividend = 8'd77;
    divisor  = 4'd6;
    start    = 1'b1;
    sb.push_back(model(8'd77, 4'd6));
    tick;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    n_checks++;
    if (done !== 1'b1 || lat != 9) begin
      n_fail++;
      $display("FAIL b2b_first_done: done=%b at %0d, need 1 at 9", done, lat);
    end
    if (done === 1'b1) begin
      e = sb.pop_front();
      n_checks++;
      if (quotient !== e.q || remainder !== e.r) begin
        n_fail++;
        $display("FAIL b2b_first: got q=%0d r=%0d, need q=%0d r=%0d",
                 quotient, remainder, e.q, e.r);
      end
    end else sb.delete();
    dividend = 8'd8;
    divisor  = 4'd8;
    sb.push_back(model(8'd8, 4'd8));
    tick;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_gap: busy=%b done=%b, need 1/0", busy, done);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_timeout: no done in %0d cycles, need done", lat);
      sb.delete();
    end else begin
      e = sb.pop_front();
      if (quotient !== e.q || remainder !== e.r || lat != 9) begin
        n_fail++;
        $display("FAIL b2b_second: got q=%0d r=%0d @%0d, need q=%0d r=%0d @9",
                 quotient, remainder, lat, e.q, e.r);
      end
    end
    tick;
  endtask

  task automatic test_sweep;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 8; k++) begin
        run_div(8'($urandom), 4'(b), "sweep");
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edges;
    test_div_by_zero;
    test_ignore_in_run;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
